// File: rtl/sram_ctrl_sync_if.sv
// rtl/sram_ctrl_sync_if.sv - host-side request/response bundle for sram_ctrl_sync
interface sram_ctrl_sync_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18
);
    localparam int BE_W = DATA_W / 8;

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic [BE_W-1:0]   be_in;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, addr_in, data_in, be_in, input ready, done, rdata);
    modport slave  (input req, wr, addr_in, data_in, be_in, output ready, done, rdata);
endinterface

// File: rtl/sram_ctrl_sync.sv
// rtl/sram_ctrl_sync.sv - cycle-counted async SRAM controller with byte lanes
module sram_ctrl_sync #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 18,
    parameter int SETUP_CYC = 2,
    parameter int WE_CYC    = 3,
    parameter int HOLD_CYC  = 2,
    parameter int READ_CYC  = 3,
    parameter int TURN_CYC  = 1
) (
    input  logic                clk,
    input  logic                rst,
    sram_ctrl_sync_if.slave     host,
    output logic [ADDR_W-1:0]   ram_addr,
    inout  wire  [DATA_W-1:0]   ram_data,
    output logic                ram_ce_n,
    output logic                ram_oe_n,
    output logic                ram_we_n,
    output logic [DATA_W/8-1:0] ram_be_n
);
    localparam int BE_W    = DATA_W / 8;
    localparam int MAX_A   = (SETUP_CYC > WE_CYC) ? SETUP_CYC : WE_CYC;
    localparam int MAX_B   = (HOLD_CYC > READ_CYC) ? HOLD_CYC : READ_CYC;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > TURN_CYC) ? MAX_C : TURN_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_R_ACCESS, S_DONE, S_TURN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic [BE_W-1:0]   be_n_q, be_n_d;
    logic              drive_q, drive_d;
    logic [DATA_W-1:0] lane_mask;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < BE_W; i++) lane_mask[8*i +: 8] = {8{be_q[i]}};

        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        be_d       = be_q;
        dout_d     = dout_q;
        ram_addr_d = ram_addr_q;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                // ready_q is the registered image of IDLE, so it gates acceptance
                if (host.req && ready_q) begin
                    wr_d       = host.wr;
                    be_d       = host.be_in;
                    dout_d     = host.data_in;
                    ram_addr_d = host.addr_in;
                    if (host.wr) begin
                        state_d = S_W_SETUP;
                        cnt_d   = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        state_d = S_R_ACCESS;
                        cnt_d   = CNT_W'(READ_CYC - 1);
                    end
                end
            end
            S_W_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_W_PULSE;
                    cnt_d   = CNT_W'(WE_CYC - 1);
                end else cnt_d = cnt_q - CNT_W'(1);
            end
            S_W_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_W_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else cnt_d = cnt_q - CNT_W'(1);
            end
            S_W_HOLD: begin
                if (cnt_q == '0) state_d = S_DONE;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            S_R_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    rdata_d = ram_data & lane_mask;
                end else cnt_d = cnt_q - CNT_W'(1);
            end
            S_DONE: begin
                if (!wr_q && (TURN_CYC > 0)) begin
                    state_d = S_TURN;
                    cnt_d   = CNT_W'(TURN_CYC - 1);
                end else state_d = S_IDLE;
            end
            S_TURN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Pin strobes are decoded from the next state so they land with it
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        drive_d = 1'b0;
        case (state_d)
            S_W_SETUP, S_W_HOLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~be_d;
                drive_d = 1'b1;
            end
            S_W_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~be_d;
                drive_d = 1'b1;
            end
            S_R_ACCESS: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = ~be_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            be_q       <= '0;
            dout_q     <= '0;
            ram_addr_q <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= '1;
            drive_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            be_q       <= be_d;
            dout_q     <= dout_d;
            ram_addr_q <= ram_addr_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
            drive_q    <= drive_d;
        end
    end

    assign host.ready = ready_q;
    assign host.done  = done_q;
    assign host.rdata = rdata_q;
    assign ram_addr   = ram_addr_q;
    assign ram_ce_n   = ce_n_q;
    assign ram_oe_n   = oe_n_q;
    assign ram_we_n   = we_n_q;
    assign ram_be_n   = be_n_q;
    assign ram_data   = drive_q ? dout_q : 'z;
endmodule

// File: tb/tb_sram_ctrl_sync.sv
// tb/tb_sram_ctrl_sync.sv - directed bench for sram_ctrl_sync (default and minimum timing)
module tb_sram_ctrl_sync;
    localparam int DW = 16;
    localparam int AW = 18;
    localparam int BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   n_total = 0;
    int   n_bad   = 0;

    sram_ctrl_sync_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
    sram_ctrl_sync_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

    logic [AW-1:0] ram_addr_a, ram_addr_b;
    wire  [DW-1:0] ram_data_a, ram_data_b;
    logic          ce_a, oe_a, we_a, ce_b, oe_b, we_b;
    logic [BW-1:0] be_n_a, be_n_b;

    sram_ctrl_sync dut_a (
        .clk(clk), .rst(rst_a), .host(ifa),
        .ram_addr(ram_addr_a), .ram_data(ram_data_a),
        .ram_ce_n(ce_a), .ram_oe_n(oe_a), .ram_we_n(we_a), .ram_be_n(be_n_a)
    );

    sram_ctrl_sync #(
        .SETUP_CYC(1), .WE_CYC(1), .HOLD_CYC(1), .READ_CYC(1), .TURN_CYC(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .host(ifb),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b),
        .ram_ce_n(ce_b), .ram_oe_n(oe_b), .ram_we_n(we_b), .ram_be_n(be_n_b)
    );

    // SRAM models: full word driven on read so controller-side lane masking is visible
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic          probe_a = 1'b0;

    assign ram_data_a = (!ce_a && !oe_a) ? mem_a[ram_addr_a[7:0]] : 'z;
    assign ram_data_a = probe_a ? 16'h0000 : 'z;
    assign ram_data_b = (!ce_b && !oe_b) ? mem_b[ram_addr_b[7:0]] : 'z;

    always @(posedge clk) begin
        if (rst_a) mem_a[8'h10] <= 16'h5A5A;
        if (!ce_a && !we_a)
            for (int i = 0; i < BW; i++)
                if (!be_n_a[i]) mem_a[ram_addr_a[7:0]][8*i +: 8] <= ram_data_a[8*i +: 8];
    end

    always @(posedge clk) begin
        if (rst_b)
            for (int i = 0; i < 8; i++) mem_b[32+i] <= 16'h0A50 + 16'(i);
        if (!ce_b && !we_b)
            for (int i = 0; i < BW; i++)
                if (!be_n_b[i]) mem_b[ram_addr_b[7:0]][8*i +: 8] <= ram_data_b[8*i +: 8];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // While the model reads, the bus must carry exactly the stored word
    always @(negedge clk) begin
        if (!oe_b) chk_eq("no_contend_b", 32'(ram_data_b), 32'(mem_b[ram_addr_b[7:0]]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int            we_first, we_cnt, done_first, done_cnt, ready_first;
    logic          bus_ok;
    logic [DW-1:0] rd_done;

    task automatic op_a(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be);
        int waited = 0;
        int win;
        while (!ifa.ready && waited < 50) begin
            tick();
            waited++;
        end
        chk_eq("ready_wait", 32'(ifa.ready), 32'd1);
        ifa.req = 1'b1; ifa.wr = w; ifa.addr_in = a; ifa.data_in = d; ifa.be_in = be;
        tick();
        ifa.req = 1'b0;
        win = w ? 7 : 3;
        we_first = 0; we_cnt = 0; done_first = 0; done_cnt = 0; ready_first = 0;
        bus_ok = 1'b1; rd_done = '0;
        for (int c = 1; c <= 14; c++) begin
            if (!we_a) begin
                we_cnt++;
                if (we_first == 0) we_first = c;
            end
            if (ifa.done) begin
                done_cnt++;
                if (done_first == 0) begin
                    done_first = c;
                    rd_done    = ifa.rdata;
                end
            end
            if (ifa.ready && ready_first == 0) ready_first = c;
            if (c <= win) begin
                if (ram_addr_a !== a || be_n_a !== ~be || ce_a !== 1'b0) bus_ok = 1'b0;
                if (w && (ram_data_a !== d || oe_a !== 1'b1)) bus_ok = 1'b0;
                if (!w && oe_a !== 1'b0) bus_ok = 1'b0;
            end
            tick();
        end
    endtask

    logic          op_wr_q [$];
    logic [DW-1:0] op_exp_q [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_acc, n_done, last_done, aborted_done;
        logic pending, op_w;
        logic [DW-1:0] op_e;

        ifa.req = 1'b0; ifa.wr = 1'b0; ifa.addr_in = '0; ifa.data_in = '0; ifa.be_in = '0;
        ifb.req = 1'b0; ifb.wr = 1'b0; ifb.addr_in = '0; ifb.data_in = '0; ifb.be_in = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        tick(); tick(); tick();

        probe_a = 1'b1;
        #1;
        chk_eq("rst_ready", 32'(ifa.ready), 32'd0);
        chk_eq("rst_done", 32'(ifa.done), 32'd0);
        chk_eq("rst_rdata", 32'(ifa.rdata), 32'd0);
        chk_eq("rst_strobes", 32'({ce_a, oe_a, we_a}), 32'h7);
        chk_eq("rst_be_n", 32'(be_n_a), 32'h3);
        chk_eq("rst_addr", 32'(ram_addr_a), 32'd0);
        chk_eq("rst_bus", 32'(ram_data_a), 32'd0);
        probe_a = 1'b0;

        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        chk_eq("ready_before_edge", 32'(ifa.ready), 32'd0);
        tick();
        chk_eq("ready_after_rst", 32'(ifa.ready), 32'd1);

        op_a(1'b1, 18'h12345, 16'hBEEF, 2'b11);
        chk_eq("wr_we_first", 32'(we_first), 32'd3);
        chk_eq("wr_we_cnt", 32'(we_cnt), 32'd3);
        chk_eq("wr_done_at", 32'(done_first), 32'd8);
        chk_eq("wr_done_cnt", 32'(done_cnt), 32'd1);
        chk_eq("wr_ready_at", 32'(ready_first), 32'd9);
        chk_eq("wr_bus", 32'(bus_ok), 32'd1);
        chk_eq("wr_mem", 32'(mem_a[8'h45]), 32'hBEEF);

        op_a(1'b0, 18'h12345, 16'h0000, 2'b11);
        chk_eq("rd_done_at", 32'(done_first), 32'd4);
        chk_eq("rd_done_cnt", 32'(done_cnt), 32'd1);
        chk_eq("rd_data", 32'(rd_done), 32'hBEEF);
        chk_eq("rd_ready_at", 32'(ready_first), 32'd6);
        chk_eq("rd_bus", 32'(bus_ok), 32'd1);

        op_a(1'b1, 18'h12345, 16'h00AA, 2'b01);
        chk_eq("lane_wr_mem", 32'(mem_a[8'h45]), 32'hBEAA);
        chk_eq("lane_wr_bus", 32'(bus_ok), 32'd1);
        op_a(1'b0, 18'h12345, 16'h0000, 2'b11);
        chk_eq("lane_rd_11", 32'(rd_done), 32'hBEAA);
        op_a(1'b0, 18'h12345, 16'h0000, 2'b01);
        chk_eq("lane_rd_01", 32'(rd_done), 32'h00AA);
        op_a(1'b0, 18'h12345, 16'h0000, 2'b10);
        chk_eq("lane_rd_10", 32'(rd_done), 32'hBE00);

        op_a(1'b1, 18'h00010, 16'h1234, 2'b00);
        chk_eq("be0_done_cnt", 32'(done_cnt), 32'd1);
        chk_eq("be0_done_at", 32'(done_first), 32'd8);
        chk_eq("be0_mem", 32'(mem_a[8'h10]), 32'h5A5A);
        chk_eq("rdata_hold", 32'(ifa.rdata), 32'hBE00);

        ifa.req = 1'b1; ifa.wr = 1'b1; ifa.addr_in = 18'h12345; ifa.data_in = 16'h1357;
        ifa.be_in = 2'b11;
        tick();
        ifa.req = 1'b0;
        tick(); tick();
        chk_eq("abort_we_low", 32'(we_a), 32'd0);
        rst_a = 1'b1;
        tick();
        probe_a = 1'b1;
        #1;
        chk_eq("abort_we", 32'(we_a), 32'd1);
        chk_eq("abort_ce", 32'(ce_a), 32'd1);
        chk_eq("abort_bus", 32'(ram_data_a), 32'd0);
        probe_a = 1'b0;
        aborted_done = 0;
        if (ifa.done) aborted_done++;
        tick();
        rst_a = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (ifa.done) aborted_done++;
            tick();
        end
        chk_eq("abort_no_done", 32'(aborted_done), 32'd0);
        chk_eq("abort_ready", 32'(ifa.ready), 32'd1);
        chk_eq("abort_mem", 32'(mem_a[8'h45] == 16'hBEAA || mem_a[8'h45] == 16'h1357), 32'd1);

        // Minimum-timing instance, req held high, ops alternate write/read
        n_acc = 0; n_done = 0; last_done = -1; pending = 1'b0;
        ifb.req = 1'b1; ifb.wr = 1'b1; ifb.addr_in = 18'd16; ifb.data_in = 16'hF000;
        ifb.be_in = 2'b11;
        for (int t = 0; t < 90; t++) begin
            if (pending) begin
                op_wr_q.push_back(ifb.wr);
                op_exp_q.push_back(16'h0A50 + 16'(n_acc / 2));
                n_acc++;
                ifb.wr      = (n_acc % 2 == 0);
                ifb.addr_in = (n_acc % 2 == 0) ? 18'(16 + n_acc / 2) : 18'(32 + n_acc / 2);
                ifb.data_in = 16'hF000 + 16'(n_acc / 2);
                if (n_acc == 12) ifb.req = 1'b0;
                pending = 1'b0;
            end
            if (ifb.done) begin
                n_done++;
                if (op_wr_q.size() == 0) begin
                    chk_eq("sweep_spurious_done", 32'd1, 32'd0);
                end else begin
                    op_w = op_wr_q.pop_front();
                    op_e = op_exp_q.pop_front();
                    if (last_done >= 0)
                        chk_eq(op_w ? "gap_write" : "gap_read", 32'(t - last_done),
                               op_w ? 32'd5 : 32'd3);
                    if (!op_w) chk_eq("sweep_rdata", 32'(ifb.rdata), 32'(op_e));
                end
                last_done = t;
            end
            if (ifb.ready && ifb.req) pending = 1'b1;
            tick();
        end
        chk_eq("sweep_done_cnt", 32'(n_done), 32'd12);
        chk_eq("sweep_acc_cnt", 32'(n_acc), 32'd12);
        for (int k = 0; k < 6; k++)
            chk_eq("sweep_mem", 32'(mem_b[16+k]), 32'(16'hF000 + 16'(k)));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
